// File: rtl/vga_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_checker
// Brief    : Receive-side VGA stream checker. Recovers line/pixel position from
//            sync edges, CRCs the active area per frame and tracks timing lock.
//            Optional expected-CRC compare: VGA_FRAME_CHECKER_COMPARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_checker #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int H_BACK         = 48,
    parameter int V_BACK         = 33,
    parameter int CLKS_PER_PIXEL = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        hs,
    input  logic        vs,
    input  logic [11:0] color_in,
`ifdef VGA_FRAME_CHECKER_COMPARE_EN
    input  logic [15:0] expected_crc,
    output logic        crc_mismatch,
`endif
    output logic        frame_valid,
    output logic [15:0] frame_crc,
    output logic        frame_ok,
    output logic [10:0] lines_per_frame,
    output logic        locked
);

    localparam int                    c_PHASE_W    = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam logic [c_PHASE_W-1:0]  c_PHASE_LAST = c_PHASE_W'(CLKS_PER_PIXEL - 1);
    localparam logic [c_PHASE_W-1:0]  c_PHASE_ONE  = c_PHASE_W'(1);
    localparam logic [10:0]           c_H_START    = 11'(H_BACK);
    localparam logic [10:0]           c_H_END      = 11'(H_BACK + H_ACTIVE);
    localparam logic [10:0]           c_V_START    = 11'(V_BACK);
    localparam logic [10:0]           c_V_END      = 11'(V_BACK + V_ACTIVE);
    localparam logic [18:0]           c_PIX_TARGET = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [15:0]           c_CRC_INIT   = 16'hFFFF;
    localparam logic [15:0]           c_CRC_POLY   = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_hs_q;
    logic                   r_vs_q;
    logic [10:0]            r_line_cnt;
    logic [c_PHASE_W-1:0]   r_phase_cnt;
    logic [10:0]            r_pix_cnt;
    logic [15:0]            r_crc;
    logic [18:0]            r_pix_total;
    logic                   w_hs_rise;
    logic                   w_vs_rise;
    logic                   w_vs_fall;
    logic                   w_sample;
    logic                   w_report;
    logic                   w_ok;
    logic [15:0]            w_crc_next;

    // CRC-16-CCITT advanced by 12 data bits, MSB first, in one step
    function automatic logic [15:0] crc_step12(input logic [15:0] crc, input logic [11:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? c_CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    assign w_hs_rise  = ~r_hs_q & hs;
    assign w_vs_rise  = ~r_vs_q & vs;
    assign w_vs_fall  = r_vs_q & ~vs;
    assign w_ok       = (r_pix_total == c_PIX_TARGET);
    assign w_crc_next = crc_step12(r_crc, color_in);

    assign w_sample = (r_state == S_FRAME) && hs && vs && (r_phase_cnt == '0) &&
                      (r_line_cnt >= c_V_START) && (r_line_cnt < c_V_END) &&
                      (r_pix_cnt >= c_H_START) && (r_pix_cnt < c_H_END);

    always_comb begin
        w_state_next = r_state;
        w_report     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_vs_rise) w_state_next = S_FRAME;
            S_FRAME:  if (w_vs_fall) w_state_next = S_REPORT;
            S_REPORT: begin
                w_report     = 1'b1;
                w_state_next = S_FRAME;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Sync history resets to the inactive level so release never fakes an edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_hs_q      <= 1'b1;
            r_vs_q      <= 1'b1;
            r_line_cnt  <= '0;
            r_phase_cnt <= '0;
            r_pix_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_hs_q  <= hs;
            r_vs_q  <= vs;
            if (w_vs_rise) begin
                r_line_cnt <= '0;
            end else if (w_hs_rise && (r_line_cnt != '1)) begin
                r_line_cnt <= r_line_cnt + 11'd1;
            end
            if (w_hs_rise) begin
                r_phase_cnt <= '0;
                r_pix_cnt   <= '0;
            end else if (r_phase_cnt == c_PHASE_LAST) begin
                r_phase_cnt <= '0;
                if (r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + 11'd1;
            end else begin
                r_phase_cnt <= r_phase_cnt + c_PHASE_ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_crc       <= c_CRC_INIT;
            r_pix_total <= '0;
        end else if (w_vs_rise) begin
            r_crc       <= c_CRC_INIT;
            r_pix_total <= '0;
        end else if (w_sample) begin
            r_crc <= w_crc_next;
            if (r_pix_total != '1) r_pix_total <= r_pix_total + 19'd1;
        end
    end

    // Lock compares the new report against the one still held on the outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_valid     <= 1'b0;
            frame_crc       <= '0;
            frame_ok        <= 1'b0;
            lines_per_frame <= '0;
            locked          <= 1'b0;
        end else begin
            frame_valid <= w_report;
            if (w_report) begin
                frame_crc       <= r_crc;
                frame_ok        <= w_ok;
                lines_per_frame <= r_line_cnt;
                locked          <= w_ok && frame_ok && (r_line_cnt == lines_per_frame);
            end
        end
    end

`ifdef VGA_FRAME_CHECKER_COMPARE_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            crc_mismatch <= 1'b0;
        end else if (w_report && w_ok && (r_crc != expected_crc)) begin
            crc_mismatch <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
